mem_port_arbiter: RTL and testbench

- Shares one single-ported unified instruction/data memory between the fetch stage (F) and the memory stage (M) of the 5-stage pipeline.
- Sequences variable-latency memory transactions through a small FSM.
- Holds fetched instructions in a one-entry tagged buffer.
- Drives stallF and stallM to the hazard logic so that no pipeline stage advances while its access is pending.

---
 rtl/mem_arb_pkg.sv | 7 +
 rtl/arb_sat_counter.sv | 17 +
 rtl/mem_port_arbiter.sv | 95 +++++++++
 tb/tb_mem_port_arbiter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared FSM state type and default widths for the memory port arbiter
package mem_arb_pkg;
    typedef enum logic [1:0] {IDLE, IFETCH, DACCESS, DDONE} arb_state_t;
    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;
    localparam int CNT_W = 32;
endpackage

// File: rtl/arb_sat_counter.sv
// arb_sat_counter: saturating stall-cycle counter with synchronous reset
// Only built when ARB_PERF_CNT_EN is defined, since nothing else instantiates it.
`ifdef ARB_PERF_CNT_EN
module arb_sat_counter
    import mem_arb_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);
    always_ff @(posedge clk) begin
        if (reset) count <= '0;
        else if (inc && count != '1) count <= count + 1'b1;
    end
endmodule
`endif

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and data stages with a one-entry tagged ibuf
// Stall perf counters are built only with ARB_PERF_CNT_EN defined; otherwise they read 0.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ireqF,
    input  logic [ADDR_W-1:0] iaddrF,
    input  logic              dreqM,
    input  logic              dweM,
    input  logic [ADDR_W-1:0] daddrM,
    input  logic [DATA_W-1:0] dwdataM,
    output logic [DATA_W-1:0] instrF,
    output logic [DATA_W-1:0] readdataM,
    output logic              stallF,
    output logic              stallM,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [CNT_W-1:0]  istall_cnt,
    output logic [CNT_W-1:0]  dstall_cnt
);
    arb_state_t state;
    logic ibufValid;
    logic [ADDR_W-1:0] ibufAddr;
    logic [DATA_W-1:0] ibufData;
    logic [DATA_W-1:0] rdataQ;
    assign stallF = ireqF && !(ibufValid && ibufAddr == iaddrF);
    assign stallM = dreqM && state != DDONE;
    assign instrF = ibufData;
    assign readdataM = rdataQ;
    // Data wins in IDLE because the instruction in M is older than the one in F.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            ibufValid <= 1'b0;
            ibufAddr <= '0;
            ibufData <= '0;
            rdataQ <= '0;
            mem_req <= 1'b0;
            mem_we <= 1'b0;
            mem_addr <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (dreqM) begin
                        state <= DACCESS;
                        mem_req <= 1'b1;
                        mem_we <= dweM;
                        mem_addr <= daddrM;
                        mem_wdata <= dwdataM;
                    end else if (stallF) begin
                        state <= IFETCH;
                        mem_req <= 1'b1;
                        mem_we <= 1'b0;
                        mem_addr <= iaddrF;
                    end
                end
                IFETCH: begin
                    if (mem_ready) begin
                        state <= IDLE;
                        mem_req <= 1'b0;
                        ibufData <= mem_rdata;
                        ibufAddr <= mem_addr;
                        ibufValid <= 1'b1;
                    end
                end
                DACCESS: begin
                    if (mem_ready) begin
                        state <= DDONE;
                        mem_req <= 1'b0;
                        if (!mem_we) rdataQ <= mem_rdata;
                        else if (mem_addr == ibufAddr) ibufValid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
`ifdef ARB_PERF_CNT_EN
    arb_sat_counter uIstall (.clk(clk), .reset(reset), .inc(stallF), .count(istall_cnt));
    arb_sat_counter uDstall (.clk(clk), .reset(reset), .inc(stallM), .count(dstall_cnt));
`else
    assign istall_cnt = '0;
    assign dstall_cnt = '0;
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scoreboard bench for mem_port_arbiter with a wait-state memory model
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;
    typedef struct {
        logic        isStore;
        logic [31:0] val;
    } dexp_t;
    logic clk, reset;
    logic ireqF, dreqM, dweM;
    logic [31:0] iaddrF, daddrM, dwdataM;
    logic [31:0] instrF, readdataM, mem_addr, mem_wdata, mem_rdata;
    logic stallF, stallM, mem_req, mem_we, mem_ready;
    logic [31:0] istall_cnt, dstall_cnt;
    logic [31:0] mem [0:127];
    logic forceReady;
    int waitStates, waitCnt;
    int nvec = 0, nfail = 0;
    logic [31:0] iq[$];
    dexp_t dq[$];

    mem_port_arbiter dut (
        .clk(clk), .reset(reset), .ireqF(ireqF), .iaddrF(iaddrF), .dreqM(dreqM), .dweM(dweM),
        .daddrM(daddrM), .dwdataM(dwdataM), .instrF(instrF), .readdataM(readdataM),
        .stallF(stallF), .stallM(stallM), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .istall_cnt(istall_cnt), .dstall_cnt(dstall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_ready = forceReady | (mem_req && waitCnt == waitStates);
    assign mem_rdata = mem[mem_addr[8:2]];
    always @(posedge clk) begin
        waitCnt <= (!mem_req || mem_ready) ? 0 : waitCnt + 1;
        if (mem_req && mem_ready && mem_we) mem[mem_addr[8:2]] = mem_wdata;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: one instruction consumed per unstalled fetch cycle, one data result per DDONE cycle.
    always @(negedge clk) begin
        if (!reset) begin
            if (ireqF && !stallF) begin
                if (iq.size() == 0) chk("instr_queue_nonempty", 32'(iq.size()), 1);
                else chk("instrF", instrF, iq.pop_front());
            end
            if (dreqM && !stallM) begin
                if (dq.size() == 0) chk("data_queue_nonempty", 32'(dq.size()), 1);
                else begin
                    dexp_t e;
                    e = dq.pop_front();
                    if (e.isStore) begin
                        chk("store_mem_we", 32'(mem_we), 1);
                        chk("store_mem_wdata", mem_wdata, e.val);
                    end else chk("readdataM", readdataM, e.val);
                end
            end
        end
    end

    task automatic fetch(input logic [31:0] a, input logic [31:0] exp, input int expStall,
                         input logic expReq, input string nm);
        int c = 0;
        logic sawReq = 1'b0, done = 1'b0;
        iq.push_back(exp);
        ireqF = 1'b1;
        iaddrF = a;
        for (int k = 0; k < 60 && !done; k++) begin
            @(negedge clk);
            if (mem_req) sawReq = 1'b1;
            if (stallF) c++;
            else done = 1'b1;
        end
        chk({nm, "_done"}, 32'(done), 1);
        chk({nm, "_stallF_cycles"}, c, expStall);
        chk({nm, "_mem_req_seen"}, 32'(sawReq), 32'(expReq));
        @(posedge clk);
        #1 ireqF = 1'b0;
    endtask

    task automatic daccess(input logic we, input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] exp, input int expStall,
                           input logic [31:0] expFirst, input string nm);
        int c = 0;
        logic done = 1'b0, got = 1'b0;
        logic [31:0] first = '0;
        dq.push_back('{we, we ? wd : exp});
        dreqM = 1'b1;
        dweM = we;
        daddrM = a;
        dwdataM = wd;
        for (int k = 0; k < 60 && !done; k++) begin
            @(negedge clk);
            if (mem_req && !got) begin
                first = mem_addr;
                got = 1'b1;
            end
            if (stallM) c++;
            else done = 1'b1;
        end
        chk({nm, "_done"}, 32'(done), 1);
        chk({nm, "_stallM_cycles"}, c, expStall);
        chk({nm, "_first_mem_addr"}, first, expFirst);
        @(posedge clk);
        #1 dreqM = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 32'hA5A5_0000 | 32'(i);
        mem[0] = 32'h2008_0005;
        mem[2] = 32'h0808_0808;
        mem[17] = 32'hDEAD_BEEF;
        mem[32] = 32'h8080_8080;
        reset = 1'b1;
        ireqF = 1'b0; dreqM = 1'b0; dweM = 1'b0;
        iaddrF = '0; daddrM = '0; dwdataM = '0;
        forceReady = 1'b0; waitStates = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_req", 32'(mem_req), 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_instrF", instrF, 0);
        chk("rst_readdataM", readdataM, 0);
        chk("rst_istall_cnt", istall_cnt, 0);
        chk("rst_dstall_cnt", dstall_cnt, 0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Fetch miss with zero-wait memory, then a hit at the same PC.
        forceReady = 1'b1;
        fetch(32'h00, 32'h2008_0005, 2, 1'b1, "miss0");
        fetch(32'h00, 32'h2008_0005, 0, 1'b0, "hit0");

        // Load with 3 wait states beats a pending fetch; fetch follows after DDONE.
        forceReady = 1'b0;
        waitStates = 3;
        fork
            fetch(32'h04, 32'hA5A5_0001, 11, 1'b1, "fetch_after_load");
            daccess(1'b0, 32'h44, 32'h0, 32'hDEAD_BEEF, 5, 32'h44, "load44");
        join

        // Data request arriving mid-fetch waits for the fetch to finish.
        waitStates = 2;
        fork
            fetch(32'h20, 32'hA5A5_0008, 4, 1'b1, "collide_fetch");
            begin
                @(posedge clk);
                #1 daccess(1'b0, 32'h48, 32'h0, 32'hA5A5_0012, 7, 32'h20, "collide_load");
            end
        join

        // PC redirect mid-fetch: old fetch completes, then refetch of new PC.
        begin
            int c;
            logic done;
            iq.push_back(32'h8080_8080);
            ireqF = 1'b1;
            iaddrF = 32'h10;
            @(negedge clk);
            @(negedge clk);
            @(posedge clk);
            #1 iaddrF = 32'h80;
            @(negedge clk);
            @(negedge clk);
            @(negedge clk);
            chk("redirect_ibuf_addr", dut.ibufAddr, 32'h10);
            chk("redirect_still_stalled", 32'(stallF), 1);
            c = 5;
            done = 1'b0;
            for (int k = 0; k < 60 && !done; k++) begin
                @(negedge clk);
                if (stallF) c++;
                else done = 1'b1;
            end
            chk("redirect_done", 32'(done), 1);
            chk("redirect_stallF_cycles", c, 8);
            chk("redirect_mem_addr", mem_addr, 32'h80);
            @(posedge clk);
            #1 ireqF = 1'b0;
        end

        // Store to the buffered address invalidates ibuf; refetch sees new data.
        waitStates = 0;
        fetch(32'h08, 32'h0808_0808, 2, 1'b1, "fill08");
        daccess(1'b1, 32'h08, 32'h1234, 32'h0, 2, 32'h08, "store08");
        chk("store_ibuf_invalid", 32'(dut.ibufValid), 0);
        fetch(32'h08, 32'h0000_1234, 2, 1'b1, "refetch08");

        // Reset while DACCESS is waiting on memory.
        waitStates = 5;
        dreqM = 1'b1;
        dweM = 1'b0;
        daddrM = 32'h44;
        @(negedge clk);
        @(negedge clk);
        chk("pre_reset_mem_req", 32'(mem_req), 1);
        @(posedge clk);
        #1 reset = 1'b1;
`ifdef ARB_PERF_CNT_EN
        @(negedge clk);
        chk("pre_reset_dstall_nonzero", 32'(dstall_cnt != 0), 1);
        chk("pre_reset_istall_nonzero", 32'(istall_cnt != 0), 1);
`endif
        @(posedge clk);
        #1 reset = 1'b0;
        dreqM = 1'b0;
        @(negedge clk);
        chk("post_reset_mem_req", 32'(mem_req), 0);
        chk("post_reset_state", 32'(dut.state), 32'(IDLE));
        chk("post_reset_istall_cnt", istall_cnt, 0);
        chk("post_reset_dstall_cnt", dstall_cnt, 0);

        repeat (3) @(posedge clk);
        chk("instr_queue_drained", 32'(iq.size()), 0);
        chk("data_queue_drained", 32'(dq.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
